calc_bcd_conv: RTL

// Sequential binary-to-BCD converter for the calculator display path. Consumes the

---
 rtl/calc_bcd_conv.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/calc_bcd_conv.sv
// calc_bcd_conv: sequential binary-to-BCD converter for the calculator display.
// Runs an iterative shift-add-3 (double dabble) conversion over WIDTH cycles
// and presents packed BCD digits, a display sign and a leading-zero blanking mask.
// The result registers bcd/sign/digit_en change only on the done pulse.
module calc_bcd_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  neg,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [DIGITS-1:0] EN_RST = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Control state
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Conversion datapath: scratch BCD digits on top of the binary shift register
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             neg_q, neg_d;
    logic             nz_q, nz_d;

    // Registered outputs
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             sign_q, sign_d;
    logic [DIGITS-1:0] en_q, en_d;

    // Helper signals
    logic [BW-1:0]     scratch_adj;
    logic [DIGITS-1:0] en_calc;
    logic              accept;

    // Add-3 correction: every scratch digit of 5 or more gets +3 before the shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: a digit is lit if it or any more significant digit
    // is non-zero; the units digit is always lit.
    always_comb begin
        logic any_nz;
        any_nz  = 1'b0;
        en_calc = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz     = any_nz | (scratch_q[4*i +: 4] != 4'd0);
            en_calc[i] = any_nz;
        end
        en_calc[0] = 1'b1;
    end

    // A new request is taken in IDLE and also in DONE, allowing back-to-back runs.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        shreg_d   = shreg_q;
        neg_d     = neg_q;
        nz_d      = nz_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        en_d      = en_q;
        done_d    = 1'b0;
        busy_d    = (state_q == CONV);

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end

            CONV: begin
                {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
                cnt_d                = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Publish the finished conversion; -0 displays as plain 0.
                bcd_d   = scratch_q;
                sign_d  = neg_q & nz_q;
                en_d    = en_calc;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Load a new operand; overrides the DONE -> IDLE transition.
        if (accept) begin
            shreg_d   = bin;
            scratch_d = '0;
            neg_d     = neg;
            nz_d      = (bin != '0);
            cnt_d     = '0;
            state_d   = CONV;
        end
    end

    // State and output registers with synchronous reset; a reset mid-conversion
    // aborts it without a done pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            shreg_q   <= '0;
            neg_q     <= 1'b0;
            nz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            en_q      <= EN_RST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            shreg_q   <= shreg_d;
            neg_q     <= neg_d;
            nz_q      <= nz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            en_q      <= en_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign sign     = sign_q;
    assign digit_en = en_q;

endmodule
